// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the multiplexed seven-segment scanner:
//   - scan_state_t : per-slot scan phase (BLANK anti-ghost gap, then ON)
//   - HEX_SEG_TABLE: active-low g..a patterns for hex digits 0..F
//   - hex_to_seg   : table lookup helper
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  // Entry [n] is the active-low segment pattern {g,f,e,d,c,b,a} for nibble n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // D
    7'b1000110,  // C
    7'b0000011,  // B
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
// Combinational hex nibble to active-low seven-segment pattern.
// Ports:
//   i_nibble : 4-bit hex value
//   o_seg    : 7-bit active-low pattern, [6:0] = g..a
// -----------------------------------------------------------------------------
module seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seven_segment_scan.sv
// -----------------------------------------------------------------------------
// seven_segment_scan
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits.
// Each digit owns a slot of DIGIT_CYCLES clocks: BLANK_CYCLES of blanking to
// stop ghosting, then an ON phase with 16-step PWM brightness. New display
// content is staged in pending registers and only becomes active at a frame
// boundary, so a frame never mixes old and new data.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   dataIn               : hex nibble per digit, digit 0 in [3:0]
//   digitDisplay/Point/Blink : per-digit enable, decimal point, blink
//   brightness           : PWM level (15 = full on, 0 = 1/16 duty)
//   load                 : one-cycle capture strobe into pending registers
//   anode                : active-low digit drive (registered)
//   segment              : active-low, [7]=DP, [6:0]=g..a (registered)
//   frame_done           : one-cycle pulse at the start of each new frame
// -----------------------------------------------------------------------------
module seven_segment_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 12500,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_BITS   = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] dataIn,
  input  logic [NUM_DIGITS-1:0]   digitDisplay,
  input  logic [NUM_DIGITS-1:0]   digitPoint,
  input  logic [NUM_DIGITS-1:0]   digitBlink,
  input  logic [3:0]              brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              segment,
  output logic                    frame_done
);

  localparam int SLOT_W = $clog2(DIGIT_CYCLES);
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  // Scan position and timing
  logic [SLOT_W-1:0]     r_slot_cnt;
  logic [IDX_W-1:0]      r_digit_idx;
  scan_state_t           r_state;
  logic [3:0]            r_pwm_cnt;
  logic [BLINK_BITS-1:0] r_blink_cnt;
  logic                  r_frame_start;

  // Staged (pending) and displayed (active) configuration
  logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
  logic [NUM_DIGITS-1:0]   r_pend_disp, r_act_disp;
  logic [NUM_DIGITS-1:0]   r_pend_point, r_act_point;
  logic [NUM_DIGITS-1:0]   r_pend_blink, r_act_blink;
  logic [3:0]              r_pend_bright, r_act_bright;
  logic                    r_pend_valid;

  // Output registers
  logic [NUM_DIGITS-1:0] r_anode;
  logic [7:0]            r_segment;
  logic                  r_frame_done;

  logic                  w_slot_end;
  logic                  w_frame_wrap;
  logic [IDX_W+1:0]      w_nib_base;
  logic [3:0]            w_cur_nibble;
  logic [6:0]            w_seg7;
  logic                  w_drive;
  logic [NUM_DIGITS-1:0] w_anode_next;
  logic [7:0]            w_segment_next;

  assign w_slot_end   = (r_slot_cnt == SLOT_W'(DIGIT_CYCLES - 1));
  assign w_frame_wrap = w_slot_end && (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_nib_base   = {r_digit_idx, 2'b00};
  assign w_cur_nibble = r_act_data[w_nib_base +: 4];

  seg_hex_decoder u_dec (
    .i_nibble (w_cur_nibble),
    .o_seg    (w_seg7)
  );

  // Slot counter, digit index, free-running blink counter and frame marker
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot_cnt    <= '0;
      r_digit_idx   <= '0;
      r_blink_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BLINK_BITS'(1);
      r_frame_start <= w_frame_wrap;
      if (w_slot_end) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= w_frame_wrap ? '0 : r_digit_idx + IDX_W'(1);
      end else begin
        r_slot_cnt  <= r_slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Per-slot BLANK/ON phase; PWM counter is held at zero while blanking so
  // every ON phase starts its duty cycle fresh
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= BLANK;
      r_pwm_cnt <= 4'd0;
    end else begin
      case (r_state)
        BLANK: begin
          r_pwm_cnt <= 4'd0;
          if (r_slot_cnt == SLOT_W'(BLANK_CYCLES - 1)) begin
            r_state <= ON;
          end
        end
        ON: begin
          r_pwm_cnt <= r_pwm_cnt + 4'd1;
          if (w_slot_end) begin
            r_state <= BLANK;
          end
        end
        default: begin
          r_state   <= BLANK;
          r_pwm_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Pending capture on load; transfer to active only at the frame wrap. A load
  // coinciding with the wrap refills pending and waits for the next wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_data   <= '0;
      r_pend_disp   <= '0;
      r_pend_point  <= '0;
      r_pend_blink  <= '0;
      r_pend_bright <= 4'd0;
      r_pend_valid  <= 1'b0;
      r_act_data    <= '0;
      r_act_disp    <= '0;
      r_act_point   <= '0;
      r_act_blink   <= '0;
      r_act_bright  <= 4'd0;
    end else begin
      if (w_frame_wrap && r_pend_valid) begin
        r_act_data   <= r_pend_data;
        r_act_disp   <= r_pend_disp;
        r_act_point  <= r_pend_point;
        r_act_blink  <= r_pend_blink;
        r_act_bright <= r_pend_bright;
      end
      if (load) begin
        r_pend_data   <= dataIn;
        r_pend_disp   <= digitDisplay;
        r_pend_point  <= digitPoint;
        r_pend_blink  <= digitBlink;
        r_pend_bright <= brightness;
        r_pend_valid  <= 1'b1;
      end else if (w_frame_wrap) begin
        r_pend_valid  <= 1'b0;
      end
    end
  end

  // Decide whether the current digit is lit this cycle and what it shows
  always_comb begin
    w_drive = (r_state == ON) &&
              (r_pwm_cnt <= r_act_bright) &&
              r_act_disp[r_digit_idx] &&
              !(r_act_blink[r_digit_idx] && r_blink_cnt[BLINK_BITS-1]);
    w_anode_next   = '1;
    w_segment_next = 8'hFF;
    if (w_drive) begin
      w_anode_next[r_digit_idx] = 1'b0;
      w_segment_next            = {~r_act_point[r_digit_idx], w_seg7};
    end else begin
      w_anode_next   = '1;
      w_segment_next = 8'hFF;
    end
  end

  // Output registers: one clock behind the internal scan state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_anode      <= '1;
      r_segment    <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_anode      <= w_anode_next;
      r_segment    <= w_segment_next;
      r_frame_done <= r_frame_start;
    end
  end

  assign anode      = r_anode;
  assign segment    = r_segment;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

  localparam int ND    = 4;
  localparam int DC    = 32;
  localparam int BC    = 4;
  localparam int BB    = 6;
  localparam int FRAME = ND * DC;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  disp;
    logic [3:0]  point;
    logic [3:0]  blink;
    logic [3:0]  bright;
  } cfg_t;

  typedef struct packed {
    int unsigned edge_n;
    cfg_t        cfg;
  } ld_t;

  typedef struct packed {
    cfg_t        cfg;
    logic [1:0]  dig;
    logic [3:0]  exp_an;
    logic [7:0]  exp_seg;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dataIn;
  logic [3:0]  digitDisplay, digitPoint, digitBlink, brightness;
  logic        load;
  logic [3:0]  anode;
  logic [7:0]  segment;
  logic        frame_done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned t        = 0;   // clock edges since reset release
  ld_t         hist[$];        // accepted loads, chronological
  logic [6:0]  hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  vec_t        vecs [8];

  seven_segment_scan #(
    .NUM_DIGITS  (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC),
    .BLINK_BITS  (BB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dataIn      (dataIn),
    .digitDisplay(digitDisplay),
    .digitPoint  (digitPoint),
    .digitBlink  (digitBlink),
    .brightness  (brightness),
    .load        (load),
    .anode       (anode),
    .segment     (segment),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Reference: output visible after edge t reflects scan cycle c = t-1.
  function automatic logic [12:0] model_out(input int unsigned tt);
    int unsigned c, slot, dig, fr, pwm;
    cfg_t        cfg;
    logic        drive;
    logic [3:0]  an;
    logic [7:0]  sg;
    if (tt == 0) return {1'b0, 4'hF, 8'hFF};
    c    = tt - 1;
    slot = c % DC;
    dig  = (c / DC) % ND;
    fr   = c / FRAME;
    cfg  = '0;
    foreach (hist[i]) if (hist[i].edge_n < FRAME * fr) cfg = hist[i].cfg;
    pwm   = (slot >= BC) ? (slot - BC) % 16 : 0;
    drive = (slot >= BC) && (pwm <= cfg.bright) && cfg.disp[dig] &&
            !(cfg.blink[dig] && ((c % (1 << BB)) >= (1 << (BB - 1))));
    an = 4'hF;
    sg = 8'hFF;
    if (drive) begin
      an[dig] = 1'b0;
      sg      = {~cfg.point[dig], hex_tab[cfg.data[4*dig +: 4]]};
    end
    return {(c > 0) && (c % FRAME == 0), an, sg};
  endfunction

  task automatic step();
    ld_t rec;
    @(posedge clk);
    #1;
    if (reset) begin
      t = 0;
      hist.delete();
    end else begin
      t++;
      if (load) begin
        rec.edge_n = t;
        rec.cfg    = {dataIn, digitDisplay, digitPoint, digitBlink, brightness};
        hist.push_back(rec);
      end
    end
    check("model", {19'd0, frame_done, anode, segment}, {19'd0, model_out(t)});
  endtask

  task automatic set_cfg(input cfg_t c);
    dataIn       = c.data;
    digitDisplay = c.disp;
    digitPoint   = c.point;
    digitBlink   = c.blink;
    brightness   = c.bright;
  endtask

  // Load a config; returns the first frame that will display it.
  task automatic load_cfg(input cfg_t c, output int unsigned f);
    set_cfg(c);
    load = 1'b1;
    step();
    load = 1'b0;
    f = t / FRAME + 1;
  endtask

  task automatic wait_t(input int unsigned target);
    for (int i = 0; i < 4000 && t < target; i++) step();
  endtask

  initial begin
    int unsigned f, first, t1, t2, cnt, rst_at;
    cfg_t c;

    vecs[0] = '{cfg: '{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF}, dig: 2'd0, exp_an: 4'b1110, exp_seg: 8'h99};
    vecs[1] = '{cfg: '{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF}, dig: 2'd3, exp_an: 4'b0111, exp_seg: 8'hF9};
    vecs[2] = '{cfg: '{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF}, dig: 2'd1, exp_an: 4'b1101, exp_seg: 8'hB0};
    vecs[3] = '{cfg: '{16'h1234, 4'hF, 4'h1, 4'h2, 4'hF}, dig: 2'd0, exp_an: 4'b1110, exp_seg: 8'h19};
    vecs[4] = '{cfg: '{16'h1234, 4'hF, 4'h1, 4'h2, 4'hF}, dig: 2'd1, exp_an: 4'b1111, exp_seg: 8'hFF};
    vecs[5] = '{cfg: '{16'hABCD, 4'h0, 4'h0, 4'h0, 4'hF}, dig: 2'd0, exp_an: 4'b1111, exp_seg: 8'hFF};
    vecs[6] = '{cfg: '{16'hABCD, 4'hF, 4'h0, 4'h0, 4'h0}, dig: 2'd2, exp_an: 4'b1011, exp_seg: 8'h83};
    vecs[7] = '{cfg: '{16'h0F5E, 4'h4, 4'h4, 4'h0, 4'h7}, dig: 2'd2, exp_an: 4'b1011, exp_seg: 8'h0E};

    reset = 1'b1;
    load  = 1'b0;
    set_cfg('0);
    repeat (3) step();
    check("rst_anode", {28'd0, anode}, 32'hF);
    check("rst_segment", {24'd0, segment}, 32'hFF);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    load = 1'b1;                       // must be ignored under reset
    step();
    load  = 1'b0;
    reset = 1'b0;

    // First lit cycle of a frame: 4 blank clocks + 1 latency after frame start
    load_cfg('{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF}, f);
    wait_t(FRAME * f);
    first = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (anode != 4'hF) begin
        first = t;
        break;
      end
    end
    check("first_on_latency", first, FRAME * f + BC + 1);

    // frame_done spacing
    t1 = 0;
    t2 = 0;
    for (int i = 0; i < 300 && t1 == 0; i++) begin step(); if (frame_done) t1 = t; end
    for (int i = 0; i < 300 && t2 == 0; i++) begin step(); if (frame_done) t2 = t; end
    check("frame_done_period", t2 - t1, FRAME);

    // Table-driven: first ON cycle of the chosen digit in the frame after load
    for (int v = 0; v < 8; v++) begin
      load_cfg(vecs[v].cfg, f);
      wait_t(FRAME * f + DC * vecs[v].dig + BC + 1);
      check($sformatf("vec%0d_anode", v), {28'd0, anode}, {28'd0, vecs[v].exp_an});
      check($sformatf("vec%0d_segment", v), {24'd0, segment}, {24'd0, vecs[v].exp_seg});
    end

    // Tear-free update: mid-frame load must not affect the current frame
    load_cfg('{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF}, f);
    wait_t(FRAME * f + DC + BC + 1);
    c = '{16'hAAAA, 4'hF, 4'h0, 4'h0, 4'hF};
    set_cfg(c);
    load = 1'b1;
    step();
    load = 1'b0;
    wait_t(FRAME * f + 2 * DC + BC + 1);
    check("tear_old_anode", {28'd0, anode}, 32'hB);
    check("tear_old_segment", {24'd0, segment}, 32'hA4);
    wait_t(FRAME * (f + 1) + BC + 1);
    check("tear_new_segment", {24'd0, segment}, 32'h88);

    // Load on the wrap edge itself goes to pending, shown one frame later
    wait_t(FRAME * (f + 2) - 1);
    set_cfg('{16'h5555, 4'hF, 4'h0, 4'h0, 4'hF});
    load = 1'b1;
    step();
    load = 1'b0;
    wait_t(FRAME * (f + 2) + BC + 1);
    check("wrap_load_old", {24'd0, segment}, 32'h88);
    wait_t(FRAME * (f + 3) + BC + 1);
    check("wrap_load_new", {24'd0, segment}, 32'h92);

    // PWM duty over 16 ON cycles of digit 0
    for (int b = 0; b < 2; b++) begin
      load_cfg('{16'h8888, 4'hF, 4'h0, 4'h0, (b == 0) ? 4'd3 : 4'd0}, f);
      wait_t(FRAME * f + BC);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (!anode[0]) cnt++;
      end
      check($sformatf("pwm_duty_b%0d", b), cnt, (b == 0) ? 32'd4 : 32'd1);
    end

    // All digits disabled: anodes never driven for a whole frame
    load_cfg('{16'h8888, 4'h0, 4'hF, 4'h0, 4'hF}, f);
    wait_t(FRAME * f);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (anode != 4'hF) cnt++;
    end
    check("display_off_frame", cnt, 32'd0);

    // Random loads plus one mid-frame reset, checked by the model every cycle
    rst_at = 600 + $urandom_range(0, 100);
    for (int i = 0; i < 1200; i++) begin
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        dataIn       = 16'($urandom);
        digitDisplay = 4'($urandom);
        digitPoint   = 4'($urandom);
        digitBlink   = 4'($urandom);
        brightness   = 4'($urandom);
      end
      reset = (i >= rst_at) && (i < rst_at + 2);
      step();
    end
    reset = 1'b0;
    load  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter DIGIT_CYCLES, default 12500, clocks per digit slot (> BLANK_CYCLES+16).
REQ-003 SHALL have parameter BLANK_CYCLES, default 500, anti-ghost blank clocks at start of each slot (>= 1).
REQ-004 SHALL have parameter BLINK_BITS, default 25, width of the free-running blink counter.
REQ-005 SHALL have ports: clk  in  1  sole clock, all logic on posedge; reset  in  1  synchronous, active-high.
REQ-006 SHALL have port: dataIn  in  4*NUM_DIGITS  hex nibble per digit, digit 0 in [3:0].
REQ-007 SHALL have ports: digitDisplay, digitPoint, digitBlink  in  NUM_DIGITS each  per-digit enable / decimal point / blink.
REQ-008 SHALL have ports: brightness  in  4  PWM duty level; load  in  1  single-cycle capture strobe.
REQ-009 SHALL have ports: anode  out  NUM_DIGITS  active-low digit drive; segment  out  8  active-low, [7]=DP, [6:0]=g..a.
REQ-010 SHALL have port: frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL capture dataIn, digitDisplay, digitPoint, digitBlink and brightness into pending registers on any cycle with load=1, setting a pending flag.
REQ-012 SHALL copy pending registers to active registers, and clear the pending flag, only on the cycle the digit index wraps NUM_DIGITS-1 -> 0; load on that same cycle loads pending, with transfer at the next wrap.
REQ-013 SHALL keep slot counter 0..DIGIT_CYCLES-1 and digit index 0..NUM_DIGITS-1, incrementing the index when the slot counter wraps.
REQ-014 SHALL run a two-state FSM per slot: BLANK for slot count 0..BLANK_CYCLES-1, then ON until slot end; back to BLANK on every slot wrap.
REQ-015 SHALL, in BLANK, drive anode all ones and segment 8'hFF.
REQ-016 SHALL, in ON, use a 4-bit PWM counter cleared on BLANK->ON and incrementing each ON cycle (wrapping 15->0), driving the digit only while pwm_cnt <= active brightness: 15 = full on, 0 = 1/16 duty.
REQ-017 SHALL drive anode[i]=0 for the current digit i only when in ON, within PWM window, active digitDisplay[i]=1 and not blink-suppressed; all other anode bits 1.
REQ-018 SHALL blink-suppress digit i when active digitBlink[i]=1 and blink counter MSB=1; the blink counter free-runs and wraps.
REQ-019 SHALL decode the current nibble with the standard hex table (0->7'b1000000 ... F->7'b0001110), and drive segment[7]=~digitPoint[i]; when the anode is not driven, segment SHALL be 8'hFF.
REQ-020 SHALL register anode, segment and frame_done: outputs reflect internal state with exactly one clock latency.
REQ-021 SHALL pulse frame_done for one cycle, one clock after the digit index wraps to 0.

Reset
REQ-022 SHALL, with reset=1 at a clock edge, set anode all ones, segment 8'hFF, frame_done 0, counters 0, digit index 0, state BLANK, pending flag 0, pending and active registers 0.
REQ-023 SHALL, on reset asserted mid-slot or mid-frame, abandon the frame; the first post-reset slot is a full slot for digit 0 starting in BLANK.
REQ-024 SHALL ignore load while reset=1.

Structure
REQ-025 SHALL place the scan_state_t enum (BLANK, ON) and the 16-entry hex-to-segment constant table in shared package seven_seg_pkg.
REQ-026 SHALL implement the nibble-to-segment lookup as sub-module seg_hex_decoder (4-bit in, 7-bit active-low out, combinational).

Verification (bench params NUM_DIGITS=4, DIGIT_CYCLES=32, BLANK_CYCLES=4, BLINK_BITS=6)
REQ-027 SHALL check reset: after reset, anode=4'hF, segment=8'hFF, frame_done=0; first anode low in slot 0 is 5 clocks after reset release (4 blank + 1 latency).
REQ-028 SHALL check scan: load dataIn=16'h1234, all enables 1, brightness=15 -> after next frame start, digit 0 shows 7'b0011001 ('4') with anode=4'b1110, digit 3 shows 7'b1111001 ('1') with anode=4'b0111, frame_done every 128 clocks.
REQ-029 SHALL check tear-free update: load 16'hAAAA mid-frame -> remaining digits of that frame still show old data; new data appears from digit 0 of the next frame.
REQ-030 SHALL check PWM: brightness=3 -> in each ON phase, anode low for 4 of every 16 cycles; brightness=0 -> 1 of 16.
REQ-031 SHALL check blink and DP: digitBlink=4'b0001, digitPoint=4'b0001 -> digit 0 anode stays high while blink MSB=1, segment[7]=0 when digit 0 shown; digitDisplay=0 -> anode=4'hF always.
